sobel_grad: RTL and testbench

Streaming 3x3 Sobel gradient stage of the Canny pipeline. Consumes the raster greyscale pixel stream framed by hvalid/vvalid and produces per-pixel signed dx, dy and a saturated gradient magnitude. Its output timing is the input timing delayed by a fixed latency, so it feeds the dx/dy/grad capture sink and the non-maximum-suppression stage unchanged. The output frame keeps the full input size, for example 1920x1080.

---
 rtl/canny_pkg.sv | 19 +
 rtl/sobel_linebuf.sv | 30 +++
 rtl/sobel_grad.sv | 211 +++++++++++++++++++++
 tb/tb_sobel_grad.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/canny_pkg.sv
// canny_pkg: constants, direction enum and helpers shared by Canny stages.
// Gradients are 11-bit signed (range +/-1020 for 8-bit pixels).
package canny_pkg;

    localparam int SOBEL_LAT = 4;
    localparam int GW        = 11;

    typedef enum logic [1:0] {
        DIR_0   = 2'd0,
        DIR_45  = 2'd1,
        DIR_90  = 2'd2,
        DIR_135 = 2'd3
    } dir_e;

    function automatic logic [GW-1:0] abs_g(input logic signed [GW-1:0] v);
        return v[GW-1] ? GW'(-v) : v;
    endfunction

endpackage

// File: rtl/sobel_linebuf.sv
// sobel_linebuf: simple dual-port line RAM, one write and one
// registered read per cycle; contents are never reset.
module sobel_linebuf #(
    parameter int DW    = 16,
    parameter int DEPTH = 1920,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sobel_grad.sv
// sobel_grad: streaming 3x3 Sobel dx/dy/magnitude, fixed 4-cycle latency.
// Define SOBEL_DIR_EN to add the quantised direction output dir_out.
module sobel_grad
    import canny_pkg::*;
#(
    parameter int IW0 = 8,
    parameter int IW1 = 8,
    parameter int HW  = 1920
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           hvalid_in,
    input  logic           vvalid_in,
    input  logic [IW0-1:0] pix_in,
    output logic           hvalid_out,
    output logic           vvalid_out,
    output logic [IW1-1:0] dx_out,
    output logic [IW1-1:0] dy_out,
    output logic [IW0-1:0] grad_out
`ifdef SOBEL_DIR_EN
    ,
    output logic [1:0]     dir_out
`endif
);
    localparam int CW = $clog2(HW + 1);
    localparam int AW = $clog2(HW);
    localparam logic [GW:0] GMAX = (GW+1)'((1 << IW0) - 1);

    logic                 w_beat;
    logic                 w_inr;
    logic                 w_rd_en;
    logic [2*IW0-1:0]     w_rd;
    logic [2*IW0-1:0]     w_wdata;
    logic [CW-1:0]        r_col;
    logic [1:0]           r_row;
    logic                 r_hv_d;
    logic [SOBEL_LAT-1:0] r_hv_p;
    logic [SOBEL_LAT-1:0] r_vv_p;
    logic                 r1_beat;
    logic                 r1_wr;
    logic                 r1_full;
    logic [AW-1:0]        r1_col;
    logic [IW0-1:0]       r1_pix;
    logic [IW0-1:0]       r2_w [3][3];
    logic                 r2_en;
    logic                 r3_en;
    logic signed [GW-1:0] r3_gx;
    logic signed [GW-1:0] r3_gy;
    logic [GW-1:0]        w_l;
    logic [GW-1:0]        w_r;
    logic [GW-1:0]        w_t;
    logic [GW-1:0]        w_b;
    logic [GW-1:0]        w_ax;
    logic [GW-1:0]        w_ay;
    logic [GW:0]          w_sum;
    logic [IW0-1:0]       w_grad;
    logic [IW1-1:0]       r_dx;
    logic [IW1-1:0]       r_dy;
    logic [IW0-1:0]       r_grad;

    assign w_beat  = hvalid_in && vvalid_in;
    assign w_inr   = r_col < CW'(HW);
    assign w_rd_en = w_beat && w_inr;
    // Word layout: upper half is row r-1, lower half is row r-2.
    assign w_wdata = {r1_pix, w_rd[2*IW0-1:IW0]};

    sobel_linebuf #(
        .DW    (2 * IW0),
        .DEPTH (HW),
        .AW    (AW)
    ) u_linebuf (
        .clk     (clk),
        .i_we    (r1_wr),
        .i_waddr (r1_col),
        .i_wdata (w_wdata),
        .i_re    (w_rd_en),
        .i_raddr (r_col[AW-1:0]),
        .o_rdata (w_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col  <= '0;
            r_row  <= '0;
            r_hv_d <= 1'b0;
        end else begin
            r_hv_d <= hvalid_in;
            if (!hvalid_in) begin
                r_col <= '0;
            end else if (w_rd_en) begin
                r_col <= r_col + 1'b1;
            end
            if (!vvalid_in) begin
                r_row <= '0;
            end else if (r_hv_d && !hvalid_in && r_row != 2'd2) begin
                r_row <= r_row + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_beat <= 1'b0;
            r1_wr   <= 1'b0;
            r1_full <= 1'b0;
            r2_en   <= 1'b0;
            r3_en   <= 1'b0;
            r_hv_p  <= '0;
            r_vv_p  <= '0;
        end else begin
            r1_beat <= w_beat;
            r1_wr   <= w_rd_en;
            r1_full <= w_rd_en && (r_row == 2'd2) && (r_col >= CW'(2));
            r2_en   <= r1_full;
            r3_en   <= r2_en;
            r_hv_p  <= {r_hv_p[SOBEL_LAT-2:0], hvalid_in};
            r_vv_p  <= {r_vv_p[SOBEL_LAT-2:0], vvalid_in};
        end
        r1_col <= r_col[AW-1:0];
        r1_pix <= pix_in;
    end

    // Column 2 is the newest column, row 2 the current input row.
    always_ff @(posedge clk) begin
        if (r1_beat) begin
            for (int i = 0; i < 3; i++) begin
                r2_w[i][0] <= r2_w[i][1];
                r2_w[i][1] <= r2_w[i][2];
            end
            r2_w[0][2] <= w_rd[IW0-1:0];
            r2_w[1][2] <= w_rd[2*IW0-1:IW0];
            r2_w[2][2] <= r1_pix;
        end
    end

    always_comb begin
        w_l = GW'(r2_w[0][0]) + (GW'(r2_w[1][0]) << 1) + GW'(r2_w[2][0]);
        w_r = GW'(r2_w[0][2]) + (GW'(r2_w[1][2]) << 1) + GW'(r2_w[2][2]);
        w_t = GW'(r2_w[0][0]) + (GW'(r2_w[0][1]) << 1) + GW'(r2_w[0][2]);
        w_b = GW'(r2_w[2][0]) + (GW'(r2_w[2][1]) << 1) + GW'(r2_w[2][2]);
    end

    always_ff @(posedge clk) begin
        r3_gx <= w_r - w_l;
        r3_gy <= w_b - w_t;
    end

    assign w_ax   = abs_g(r3_gx);
    assign w_ay   = abs_g(r3_gy);
    assign w_sum  = ({1'b0, w_ax} + {1'b0, w_ay}) >> 2;
    assign w_grad = (w_sum > GMAX) ? '1 : w_sum[IW0-1:0];

    always_ff @(posedge clk) begin
        if (rst || !r3_en) begin
            r_dx   <= '0;
            r_dy   <= '0;
            r_grad <= '0;
        end else begin
            r_dx   <= IW1'(r3_gx >>> 3);
            r_dy   <= IW1'(r3_gy >>> 3);
            r_grad <= w_grad;
        end
    end

`ifdef SOBEL_DIR_EN
    localparam int PW = GW + 3;

    logic [PW-1:0] w_ax2;
    logic [PW-1:0] w_ax5;
    logic [PW-1:0] w_ay2;
    logic [PW-1:0] w_ay5;
    dir_e          w_dir;
    dir_e          r_dir;

    assign w_ax2 = PW'({w_ax, 1'b0});
    assign w_ay2 = PW'({w_ay, 1'b0});
    assign w_ax5 = PW'({w_ax, 2'b00}) + PW'(w_ax);
    assign w_ay5 = PW'({w_ay, 2'b00}) + PW'(w_ay);

    // Sectors split at tan = 2/5 and 5/2; a flat gradient lands in DIR_0.
    always_comb begin
        w_dir = DIR_0;
        if (w_ay5 <= w_ax2) begin
            w_dir = DIR_0;
        end else if (w_ay2 >= w_ax5) begin
            w_dir = DIR_90;
        end else if (r3_gx[GW-1] == r3_gy[GW-1]) begin
            w_dir = DIR_45;
        end else begin
            w_dir = DIR_135;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !r3_en) begin
            r_dir <= DIR_0;
        end else begin
            r_dir <= w_dir;
        end
    end

    assign dir_out = r_dir;
`endif

    assign hvalid_out = r_hv_p[SOBEL_LAT-1];
    assign vvalid_out = r_vv_p[SOBEL_LAT-1];
    assign dx_out     = r_dx;
    assign dy_out     = r_dy;
    assign grad_out   = r_grad;

endmodule

// File: tb/tb_sobel_grad.sv
// tb_sobel_grad: directed frames for sobel_grad with a frame-based reference.
// Build with SOBEL_DIR_EN defined to also exercise dir_out.
module tb_sobel_grad;
    localparam int HW = 16;
    localparam int MH = 12;
    localparam int MW = 24;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hvalid_in = 1'b0;
    logic       vvalid_in = 1'b0;
    logic [7:0] pix_in = 8'd0;
    logic       hvalid_out;
    logic       vvalid_out;
    logic [7:0] dx_out;
    logic [7:0] dy_out;
    logic [7:0] grad_out;
    logic [1:0] w_dir;
`ifdef SOBEL_DIR_EN
    logic [1:0] dir_out;
    assign w_dir = dir_out;
`else
    assign w_dir = 2'b00;
`endif

    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  img [MH][MW];
    logic [31:0] cap [MH][MW];
    logic [3:0]  hv_h = 4'd0;
    logic [3:0]  vv_h = 4'd0;
    bit          vchk = 1'b0;
    int          ox = 0;
    int          oy = 0;
    int          n_out = 0;
    logic        ohv_d = 1'b0;

    always #5 clk = ~clk;

    sobel_grad #(.IW0(8), .IW1(8), .HW(HW)) dut (
        .clk        (clk),
        .rst        (rst),
        .hvalid_in  (hvalid_in),
        .vvalid_in  (vvalid_in),
        .pix_in     (pix_in),
        .hvalid_out (hvalid_out),
        .vvalid_out (vvalid_out),
        .dx_out     (dx_out),
        .dy_out     (dy_out),
        .grad_out   (grad_out)
`ifdef SOBEL_DIR_EN
        ,
        .dir_out    (dir_out)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int px(input int y, input int x);
        return int'(img[y][x]);
    endfunction

    // Reference output for output row ry (rows since restart), image row y.
    function automatic logic [31:0] sobel_ref(input int y, input int ry,
                                              input int x);
        int gx, gy, ax, ay, g;
        logic [7:0] dx, dy;
        logic [1:0] d;
        if (ry < 2 || x < 2 || x >= HW) return 32'd0;
        gx = (px(y-2,x) + 2*px(y-1,x) + px(y,x))
           - (px(y-2,x-2) + 2*px(y-1,x-2) + px(y,x-2));
        gy = (px(y,x-2) + 2*px(y,x-1) + px(y,x))
           - (px(y-2,x-2) + 2*px(y-2,x-1) + px(y-2,x));
        dx = 8'(gx >>> 3);
        dy = 8'(gy >>> 3);
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        g  = (ax + ay) >> 2;
        if (g > 255) g = 255;
        if (5*ay <= 2*ax) d = 2'd0;
        else if (2*ay >= 5*ax) d = 2'd2;
        else if ((gx < 0) == (gy < 0)) d = 2'd1;
        else d = 2'd3;
`ifndef SOBEL_DIR_EN
        d = 2'd0;
`endif
        return {6'd0, d, dx, dy, 8'(g)};
    endfunction

    always @(posedge clk) begin
        hv_h <= {hv_h[2:0], hvalid_in};
        vv_h <= {vv_h[2:0], vvalid_in};
    end

    always @(negedge clk) begin
        if (vchk) begin
            check("hv_lat", 32'(hvalid_out), 32'(hv_h[3]));
            check("vv_lat", 32'(vvalid_out), 32'(vv_h[3]));
        end
        if (hvalid_out && vvalid_out) begin
            if (oy < MH && ox < MW)
                cap[oy][ox] = {6'd0, w_dir, dx_out, dy_out, grad_out};
            ox++;
            n_out++;
        end
        if (!vvalid_out) oy = 0;
        else if (ohv_d && !hvalid_out) oy++;
        if (!hvalid_out) ox = 0;
        ohv_d = hvalid_out;
    end

    task automatic send_frame(input int h, input int w, input int rrow);
        int nr;
        for (int y = 0; y < MH; y++)
            for (int x = 0; x < MW; x++) cap[y][x] = 32'hDEADBEEF;
        n_out = 0;
        hvalid_in = 1'b1;
        vvalid_in = 1'b0;
        repeat (3) @(negedge clk);
        hvalid_in = 1'b0;
        repeat (2) @(negedge clk);
        vvalid_in = 1'b1;
        @(negedge clk);
        for (int y = 0; y < h; y++) begin
            nr = 0;
            for (int x = 0; x < w; x++) begin
                hvalid_in = 1'b1;
                pix_in = img[y][x];
                if (y == rrow && x == w / 2) begin
                    rst = 1'b1;
                    vchk = 1'b0;
                end
                @(negedge clk);
                if (rst) begin
                    nr++;
                    if (nr == 1) begin
                        check("rst_hv", 32'(hvalid_out), 32'd0);
                        check("rst_vv", 32'(vvalid_out), 32'd0);
                        check("rst_data", {8'd0, dx_out, dy_out, grad_out}, 32'd0);
                    end
                    if (nr == 3) break;
                end
            end
            hvalid_in = 1'b0;
            pix_in = 8'd0;
            if (rst) begin
                rst = 1'b0;
                repeat (6) @(negedge clk);
                vchk = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        repeat (2) @(negedge clk);
        vvalid_in = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic compare_frame(input int h, input int w, input int y0);
        for (int oyy = 0; oyy < h - y0; oyy++)
            for (int x = 0; x < w; x++)
                check($sformatf("px_r%0d_c%0d", oyy, x), cap[oyy][x],
                      sobel_ref(y0 + oyy, oyy, x));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_hv", 32'(hvalid_out), 32'd0);
        check("reset_vv", 32'(vvalid_out), 32'd0);
        check("reset_data", {6'd0, w_dir, dx_out, dy_out, grad_out}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        vchk = 1'b1;

        for (int y = 0; y < MH; y++)
            for (int x = 0; x < MW; x++) img[y][x] = 8'h80;
        send_frame(6, 12, -1);
        check("flat_count", 32'(n_out), 32'd72);
        compare_frame(6, 12, 0);

        for (int y = 0; y < MH; y++)
            for (int x = 0; x < MW; x++) img[y][x] = (x < 6) ? 8'd0 : 8'd255;
        send_frame(6, 12, -1);
        check("vstep_count", 32'(n_out), 32'd72);
        check("vstep_c6", {8'd0, cap[3][6][23:0]}, 32'h7F00FF);
        check("vstep_c7", {8'd0, cap[3][7][23:0]}, 32'h7F00FF);
        check("vstep_c5", cap[3][5], 32'd0);
        check("vstep_c8", cap[3][8], 32'd0);
        check("vstep_row1", cap[1][6], 32'd0);
        compare_frame(6, 12, 0);

        for (int y = 0; y < MH; y++)
            for (int x = 0; x < MW; x++) img[y][x] = (y < 4) ? 8'd0 : 8'd255;
        send_frame(8, 10, -1);
        check("hstep_r4", {8'd0, cap[4][5][23:0]}, 32'h007FFF);
        check("hstep_r5", {8'd0, cap[5][5][23:0]}, 32'h007FFF);
        check("hstep_r6", cap[6][5], 32'd0);
        compare_frame(8, 10, 0);

        for (int y = 0; y < MH; y++)
            for (int x = 0; x < MW; x++) img[y][x] = (y < 4) ? 8'd255 : 8'd0;
        send_frame(8, 10, -1);
        check("ihstep_r4", {8'd0, cap[4][5][23:0]}, 32'h0080FF);
        compare_frame(8, 10, 0);

        for (int y = 0; y < MH; y++)
            for (int x = 0; x < MW; x++) img[y][x] = 8'($urandom_range(0, 255));
        send_frame(6, 18, -1);
        check("wide_count", 32'(n_out), 32'd108);
        check("wide_c16", cap[3][16], 32'd0);
        check("wide_c17", cap[4][17], 32'd0);
        check("rand_r0", cap[0][5], 32'd0);
        check("rand_r1", cap[1][9], 32'd0);
        check("rand_c0", cap[3][0], 32'd0);
        check("rand_c1", cap[4][1], 32'd0);
        compare_frame(6, 18, 0);

        for (int y = 0; y < MH; y++)
            for (int x = 0; x < MW; x++) img[y][x] = 8'($urandom_range(0, 255));
        send_frame(10, 12, 4);
        compare_frame(10, 12, 5);

        for (int y = 0; y < MH; y++)
            for (int x = 0; x < MW; x++) img[y][x] = 8'(y + x);
        send_frame(6, 10, -1);
        check("diag_val", {8'd0, cap[3][5][23:0]}, 32'h010104);
`ifdef SOBEL_DIR_EN
        check("diag_dir", 32'(cap[3][5][25:24]), 32'd1);
`endif
        compare_frame(6, 10, 0);

        for (int y = 0; y < MH; y++)
            for (int x = 0; x < MW; x++) img[y][x] = 8'(100 + y - x);
        send_frame(6, 10, -1);
        check("anti_val", {8'd0, cap[3][5][23:0]}, 32'hFF0104);
`ifdef SOBEL_DIR_EN
        check("anti_dir", 32'(cap[3][5][25:24]), 32'd3);
`endif
        compare_frame(6, 10, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
